// File: rtl/mnist_pkg.sv
// Shared types and default sizing for the MNIST image streamer.
package mnist_pkg;
  localparam int unsigned DEFAULT_DATA_WIDTH     = 16;
  localparam int unsigned DEFAULT_NUM_PIXELS     = 784;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DIGIT_W                = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/pixel_buffer.sv
// Single-port image store: synchronous write, registered read, array not reset.
module pixel_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 784,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      o_rdata <= r_mem[i_addr];
    end
  end
endmodule

// File: rtl/image_streamer.sv
// Buffers one image from the host, replays it to the accelerator core, and
// returns the predicted digit (or a timeout flag) through a result handshake.
module image_streamer
  import mnist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_PIXELS     = DEFAULT_NUM_PIXELS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_pixel,
  output logic                  core_rst,
  output logic                  core_i_valid,
  output logic [DATA_WIDTH-1:0] core_pixel,
  input  logic                  core_o_valid,
  input  logic [DIGIT_W-1:0]    core_digit,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DIGIT_W-1:0]    r_digit,
  output logic                  r_timeout,
  output logic                  busy
);
  localparam int unsigned CNT_W  = $clog2(NUM_PIXELS + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ADDR_W = $clog2(NUM_PIXELS);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_out_cnt;
  logic [TMO_W-1:0]      r_wait_cnt;
  logic                  r_rd_vld;
  logic                  w_we;
  logic                  w_re;
  logic                  w_tmo;
  logic [DATA_WIDTH-1:0] w_rdata;

  pixel_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_PIXELS),
    .ADDR_W     (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_cnt[ADDR_W-1:0]),
    .i_wdata (s_pixel),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // r_cnt is the write index in LOAD and the read index in STREAM.
  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_re   = 1'b0;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE: w_next = LOAD;
      LOAD: begin
        if (s_valid && s_ready) begin
          w_we = 1'b1;
          if (r_cnt == CNT_W'(NUM_PIXELS - 1)) w_next = STREAM;
        end
      end
      STREAM: begin
        w_re = (r_cnt < CNT_W'(NUM_PIXELS));
        if (core_i_valid && (r_out_cnt == CNT_W'(NUM_PIXELS - 1))) w_next = WAIT;
      end
      WAIT: begin
        if (core_o_valid) begin
          w_next = DONE;
        end else if (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_tmo  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: if (r_valid && r_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status flags track the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_out_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_rd_vld     <= 1'b0;
      s_ready      <= 1'b0;
      core_rst     <= 1'b1;
      busy         <= 1'b0;
      core_i_valid <= 1'b0;
      core_pixel   <= '0;
      r_valid      <= 1'b0;
      r_digit      <= '0;
      r_timeout    <= 1'b0;
    end else begin
      core_rst     <= (w_next == IDLE);
      s_ready      <= (w_next == LOAD);
      busy         <= (w_next != IDLE);
      r_valid      <= (w_next == DONE);
      r_rd_vld     <= w_re;
      core_i_valid <= r_rd_vld;
      core_pixel   <= r_rd_vld ? w_rdata : '0;

      case (r_state)
        LOAD:    if (w_we) r_cnt <= (w_next == STREAM) ? '0 : r_cnt + CNT_W'(1);
        STREAM:  if (w_re) r_cnt <= r_cnt + CNT_W'(1);
        default: r_cnt <= '0;
      endcase

      if (r_state != STREAM)  r_out_cnt <= '0;
      else if (core_i_valid)  r_out_cnt <= r_out_cnt + CNT_W'(1);

      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + TMO_W'(1) : '0;

      if (r_state == WAIT) begin
        if (core_o_valid) begin
          r_digit   <= core_digit;
          r_timeout <= 1'b0;
        end else if (w_tmo) begin
          r_digit   <= '0;
          r_timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_image_streamer.sv
// Directed/randomized bench for image_streamer with a behavioural image model.
module tb_image_streamer;
  localparam int DW = 16;
  localparam int N  = 784;
  localparam int T  = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_pixel;
  logic          core_rst;
  logic          core_i_valid;
  logic [DW-1:0] core_pixel;
  logic          core_o_valid;
  logic [3:0]    core_digit;
  logic          r_valid;
  logic          r_ready;
  logic [3:0]    r_digit;
  logic          r_timeout;
  logic          busy;

  image_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_pixel      (s_pixel),
    .core_rst     (core_rst),
    .core_i_valid (core_i_valid),
    .core_pixel   (core_pixel),
    .core_o_valid (core_o_valid),
    .core_digit   (core_digit),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_digit      (r_digit),
    .r_timeout    (r_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rst = 0, n_srdy = 0, n_runs = 0, n_zero_err = 0, n_busy_err = 0;
  bit prev_v = 1'b0;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] img [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records streamed pixels and per-cycle protocol counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_rst) n_rst++;
      if (s_ready) n_srdy++;
      if (busy === core_rst) n_busy_err++;
    end
    if (core_i_valid) got_q.push_back(core_pixel);
    if (core_i_valid && !prev_v) n_runs++;
    if (!core_i_valid && core_pixel !== '0) n_zero_err++;
    prev_v = core_i_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_core_i_valid"}, 32'(core_i_valid), 0);
    check({tag, "_core_pixel"}, 32'(core_pixel), 0);
    check({tag, "_r_valid"}, 32'(r_valid), 0);
    check({tag, "_r_digit"}, 32'(r_digit), 0);
    check({tag, "_r_timeout"}, 32'(r_timeout), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_core_rst"}, 32'(core_rst), 1);
  endtask

  // mode: 0 valid always high, 1 toggling, 2 random. resp < 0: core silent.
  task automatic run_image(input int mode, input bit noise, input int resp,
                           input logic [3:0] digit, input int rdy_hold, input int abort_at);
    int  base_q, base_rst, base_srdy, base_runs, idx, ncy, nbad, w0, bad;
    bit  ok, v;
    logic [3:0] exp_digit;
    logic       exp_tmo;
    base_q = got_q.size(); base_rst = n_rst; base_srdy = n_srdy; base_runs = n_runs;

    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s_ready) begin ok = 1'b1; break; end
      s_valid = noise; s_pixel = DW'($urandom);
      @(posedge clk); #1;
    end
    check("load_entry", 32'(ok), 1);

    idx = 0; ncy = 0;
    while (idx < N && ncy < 8 * N) begin
      if (abort_at > 0 && idx == abort_at) break;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (ncy % 2 == 0) : ($urandom_range(0, 1) == 1);
      s_valid = v;
      s_pixel = v ? img[idx] : DW'($urandom);
      core_o_valid = noise && ($urandom_range(0, 7) == 0);
      core_digit = 4'($urandom);
      r_ready = noise && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      ncy++;
      if (v) idx++;
    end

    if (abort_at > 0) begin
      rst = 1'b1; #1;
      check_reset_vals("abort");
      s_valid = 1'b0; core_o_valid = 1'b0; r_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      return;
    end

    s_valid = noise; s_pixel = DW'($urandom); core_o_valid = 1'b0; r_ready = 1'b0;
    check("s_ready_drop", 32'(s_ready), 0);
    check("load_cycles", 32'(n_srdy - base_srdy), 32'(ncy));
    check("core_rst_pulse", 32'(n_rst - base_rst), 1);

    ok = 1'b0;
    for (int i = 0; i < N + 10; i++) begin
      if (!core_i_valid && (got_q.size() - base_q == N)) begin ok = 1'b1; break; end
      core_o_valid = noise && ($urandom_range(0, 3) == 0);
      core_digit = 4'($urandom);
      s_pixel = DW'($urandom);
      @(posedge clk); #1;
    end
    core_o_valid = 1'b0;
    check("stream_done", 32'(ok), 1);
    check("stream_len", 32'(got_q.size() - base_q), N);
    nbad = 0;
    for (int k = 0; k < N; k++)
      if (base_q + k < got_q.size() && got_q[base_q + k] !== img[k]) nbad++;
    check("stream_data", 32'(nbad), 0);
    check("stream_contig", 32'(n_runs - base_runs), 1);

    w0 = cyc;
    if (resp >= 0) begin
      repeat (resp) begin @(posedge clk); #1; end
      core_o_valid = 1'b1; core_digit = digit;
      @(posedge clk); #1;
      core_o_valid = 1'b0; core_digit = 4'($urandom);
    end
    ok = 1'b0;
    for (int i = 0; i < T + 10; i++) begin
      if (r_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("result_valid", 32'(ok), 1);
    check("wait_cycles", 32'(cyc - w0), (resp >= 0 && resp < T) ? 32'(resp + 1) : 32'(T));
    exp_digit = (resp >= 0 && resp < T) ? digit : 4'd0;
    exp_tmo   = !(resp >= 0 && resp < T);
    check("r_digit", 32'(r_digit), 32'(exp_digit));
    check("r_timeout", 32'(r_timeout), 32'(exp_tmo));

    bad = 0;
    for (int i = 0; i < rdy_hold; i++) begin
      core_o_valid = noise && ($urandom_range(0, 1) == 1);
      core_digit = 4'($urandom);
      @(posedge clk); #1;
      if (r_valid !== 1'b1 || r_digit !== exp_digit || r_timeout !== exp_tmo) bad++;
    end
    core_o_valid = 1'b0;
    check("done_stable", 32'(bad), 0);

    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    check("post_hs_r_valid", 32'(r_valid), 0);
    check("post_hs_core_rst", 32'(core_rst), 1);
    check("post_hs_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_pixel = '0; core_o_valid = 1'b0;
    core_digit = '0; r_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst = 1'b0;

    for (int k = 0; k < N; k++) img[k] = DW'(k);
    run_image(0, 1'b0, 100, 4'd7, 10, 0);
    run_image(1, 1'b0, $urandom_range(0, 50), 4'($urandom), $urandom_range(0, 5), 0);

    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    run_image(2, 1'b0, -1, 4'd0, 3, 0);

    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    run_image(0, 1'b0, 0, 4'd0, 0, 300);
    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    run_image(0, 1'b0, 20, 4'($urandom), 2, 0);

    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    run_image(2, 1'b1, $urandom_range(0, 200), 4'($urandom), $urandom_range(1, 8), 0);

    for (int k = 0; k < N; k++) img[k] = DW'($urandom);
    run_image(0, 1'b0, T - 1, 4'($urandom_range(1, 15)), 1, 0);

    check("pixel_zero_when_invalid", 32'(n_zero_err), 0);
    check("busy_vs_idle", 32'(n_busy_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
